// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - Synchronous FIFO with any DEPTH >= 2, standard or first-word-fall-through read.
// Optional error flags (overflow/underflow/err_clr) are enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo_fwft #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
`ifdef SYNC_FIFO_ERR_EN
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow,
`endif
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || AFULL_TH > DEPTH || AEMPTY_TH > DEPTH) begin : g_bad_cfg
        $fatal(1, "sync_fifo_fwft: illegal DEPTH/AFULL_TH/AEMPTY_TH combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CNT_W'(AFULL_TH));
    assign almost_empty = (cnt_q <= CNT_W'(AEMPTY_TH));
    assign count        = cnt_q;
    assign wr_ready     = !full;

    // Flush discards any push or pop requested in the same cycle.
    assign push = wr_valid && !full && !flush;
    assign pop  = rd_ready && !empty && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; forced to zero while empty so reset shows 0.
        assign rd_valid = !empty;
        assign rd_data  = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end else begin
                rd_valid <= pop;
                if (pop) rd_data <= mem[rd_ptr];
            end
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_valid && full)       overflow <= 1'b1;
            else if (err_clr)           overflow <= 1'b0;
            if (rd_ready && empty)      underflow <= 1'b1;
            else if (err_clr)           underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb/tb_sync_fifo_fwft.sv - Directed scoreboard bench for sync_fifo_fwft in both read modes.
module tb_sync_fifo_fwft;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=5 standard read
    logic        fl5 = 0, wv5 = 0, rr5 = 0;
    logic [15:0] wd5 = 0;
    logic        wrr5, rv5, full5, emp5, af5, ae5;
    logic [15:0] rdd5;
    logic [2:0]  cnt5;
    // DEPTH=4 FWFT
    logic        fl4 = 0, wv4 = 0, rr4 = 0;
    logic [15:0] wd4 = 0;
    logic        wrr4, rv4, full4, emp4, af4, ae4;
    logic [15:0] rdd4;
    logic [2:0]  cnt4;
    // DEPTH=8 custom thresholds
    logic        fl8 = 0, wv8 = 0, rr8 = 0;
    logic [15:0] wd8 = 0;
    logic        wrr8, rv8, full8, emp8, af8, ae8;
    logic [15:0] rdd8;
    logic [3:0]  cnt8;
`ifdef SYNC_FIFO_ERR_EN
    logic ec5 = 0, of5, uf5;
    logic of4, uf4, of8, uf8;
`endif

    sync_fifo_fwft #(.DEPTH(5), .WIDTH(16), .FWFT(0)) u5 (
        .clk(clk), .rstn(rstn), .flush(fl5),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(ec5), .overflow(of5), .underflow(uf5),
`endif
        .wr_valid(wv5), .wr_ready(wrr5), .wr_data(wd5),
        .rd_ready(rr5), .rd_valid(rv5), .rd_data(rdd5), .count(cnt5),
        .full(full5), .empty(emp5), .almost_full(af5), .almost_empty(ae5));

    sync_fifo_fwft #(.DEPTH(4), .WIDTH(16), .FWFT(1)) u4 (
        .clk(clk), .rstn(rstn), .flush(fl4),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(1'b0), .overflow(of4), .underflow(uf4),
`endif
        .wr_valid(wv4), .wr_ready(wrr4), .wr_data(wd4),
        .rd_ready(rr4), .rd_valid(rv4), .rd_data(rdd4), .count(cnt4),
        .full(full4), .empty(emp4), .almost_full(af4), .almost_empty(ae4));

    sync_fifo_fwft #(.DEPTH(8), .WIDTH(16), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)) u8 (
        .clk(clk), .rstn(rstn), .flush(fl8),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(1'b0), .overflow(of8), .underflow(uf8),
`endif
        .wr_valid(wv8), .wr_ready(wrr8), .wr_data(wd8),
        .rd_ready(rr8), .rd_valid(rv8), .rd_data(rdd8), .count(cnt8),
        .full(full8), .empty(emp8), .almost_full(af8), .almost_empty(ae8));

    int passed = 0;
    int total  = 0;
    int failed = 0;
    logic [15:0] sb5[$];
    logic [15:0] sb4[$];
    logic [15:0] exp_w;
    logic [15:0] last5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_count5", 32'(cnt5), 0);
        chk("rst_empty5", 32'(emp5), 1);
        chk("rst_full5", 32'(full5), 0);
        chk("rst_ae5", 32'(ae5), 1);
        chk("rst_af5", 32'(af5), 0);
        chk("rst_rv5", 32'(rv5), 0);
        chk("rst_rd5", 32'(rdd5), 0);
        chk("rst_wrr5", 32'(wrr5), 1);
        chk("rst_rv4", 32'(rv4), 0);
        chk("rst_rd4", 32'(rdd4), 0);
        chk("rst_ae8", 32'(ae8), 1);
        rstn = 1'b1;
        tick();

        // Fill DEPTH=5 to full, then a dropped 6th write
        for (int i = 1; i <= 6; i++) begin
            wv5 = 1; wd5 = 16'(i);
            if (sb5.size() < 5) sb5.push_back(16'(i));
            tick();
        end
        wv5 = 0;
        chk("fill_count5", 32'(cnt5), 5);
        chk("fill_full5", 32'(full5), 1);
        chk("fill_wrr5", 32'(wrr5), 0);
        rr5 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_w = sb5.pop_front();
            chk("rd_valid5", 32'(rv5), 1);
            chk("rd_data5", 32'(rdd5), 32'(exp_w));
        end
        rr5 = 0;
        chk("drain_empty5", 32'(emp5), 1);
        tick();
        chk("idle_rv5", 32'(rv5), 0);
        chk("hold_rd5", 32'(rdd5), 32'h5);

        // Alternating write/read across pointer wrap
        for (int i = 0; i < 13; i++) begin
            if (i % 2 == 0) begin
                wv5 = 1; rr5 = 0; wd5 = 16'(16'h100 + i);
                sb5.push_back(wd5);
                tick();
                chk("wrap_cnt_w", 32'(cnt5), 1);
            end else begin
                wv5 = 0; rr5 = 1;
                tick();
                exp_w = sb5.pop_front();
                chk("wrap_rv", 32'(rv5), 1);
                chk("wrap_data", 32'(rdd5), 32'(exp_w));
                chk("wrap_cnt_r", 32'(cnt5), 0);
            end
        end
        wv5 = 0; rr5 = 1;
        tick();
        rr5 = 0;
        exp_w = sb5.pop_front();
        last5 = exp_w;
        chk("wrap_last", 32'(rdd5), 32'(exp_w));

        // Flush at count=3 with simultaneous write and read
        for (int i = 1; i <= 3; i++) begin
            wv5 = 1; wd5 = 16'(16'h200 + i);
            sb5.push_back(wd5);
            tick();
        end
        wv5 = 0;
        chk("pre_flush_cnt", 32'(cnt5), 3);
        fl5 = 1; wv5 = 1; wd5 = 16'hBEEF; rr5 = 1;
        tick();
        fl5 = 0; wv5 = 0; rr5 = 0;
        sb5.delete();
        chk("flush_cnt", 32'(cnt5), 0);
        chk("flush_empty", 32'(emp5), 1);
        chk("flush_rv", 32'(rv5), 0);
        chk("flush_rd_hold", 32'(rdd5), 32'(last5));
        wv5 = 1; wd5 = 16'h0042;
        tick();
        wv5 = 0; rr5 = 1;
        tick();
        rr5 = 0;
        chk("post_flush_rv", 32'(rv5), 1);
        chk("post_flush_data", 32'(rdd5), 32'h42);
        chk("post_flush_cnt", 32'(cnt5), 0);

        // FWFT DEPTH=4: fill, then read+write while full
        for (int i = 0; i < 4; i++) begin
            wv4 = 1; wd4 = 16'(16'hA0 + i);
            sb4.push_back(wd4);
            tick();
            if (i == 0) begin
                chk("fwft_lat_rv", 32'(rv4), 1);
                chk("fwft_lat_data", 32'(rdd4), 32'hA0);
            end
        end
        chk("fwft_full", 32'(full4), 1);
        chk("fwft_cnt4", 32'(cnt4), 4);
        wv4 = 1; wd4 = 16'hA4; rr4 = 1;
        exp_w = sb4.pop_front();
        chk("fwft_full_rd", 32'(rdd4), 32'(exp_w));
        tick();
        chk("fwft_pop_only", 32'(cnt4), 3);
        wd4 = 16'hA5;
        sb4.push_back(wd4);
        exp_w = sb4.pop_front();
        chk("fwft_pp_rd", 32'(rdd4), 32'(exp_w));
        tick();
        chk("fwft_pp_cnt", 32'(cnt4), 3);
        wv4 = 0;
        for (int i = 0; i < 3; i++) begin
            exp_w = sb4.pop_front();
            chk("fwft_drain_rv", 32'(rv4), 1);
            chk("fwft_drain_rd", 32'(rdd4), 32'(exp_w));
            tick();
        end
        rr4 = 0;
        chk("fwft_empty", 32'(emp4), 1);
        chk("fwft_empty_rv", 32'(rv4), 0);

        // Threshold flags, DEPTH=8, AFULL_TH=6, AEMPTY_TH=1
        for (int n = 1; n <= 8; n++) begin
            wv8 = 1; wd8 = 16'(n);
            tick();
            chk("th_cnt", 32'(cnt8), 32'(n));
            chk("th_ae", 32'(ae8), (n <= 1) ? 1 : 0);
            chk("th_af", 32'(af8), (n >= 6) ? 1 : 0);
            chk("th_full", 32'(full8), (n == 8) ? 1 : 0);
        end
        wv8 = 0;

`ifdef SYNC_FIFO_ERR_EN
        rr5 = 1;
        tick();
        rr5 = 0;
        chk("uf_set", 32'(uf5), 1);
        tick();
        chk("uf_sticky", 32'(uf5), 1);
        chk("uf_cnt", 32'(cnt5), 0);
        for (int i = 0; i < 6; i++) begin
            wv5 = 1; wd5 = 16'(16'h300 + i);
            tick();
        end
        wv5 = 0;
        chk("of_set", 32'(of5), 1);
        chk("of_cnt", 32'(cnt5), 5);
        ec5 = 1;
        tick();
        ec5 = 0;
        chk("clr_of", 32'(of5), 0);
        chk("clr_uf", 32'(uf5), 0);
        chk("clr_cnt", 32'(cnt5), 5);
`endif

        // Asynchronous reset in mid-transfer
        wv4 = 1; wd4 = 16'h0055;
        tick();
        wv4 = 0;
        chk("pre_rst_rv4", 32'(rv4), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_cnt4", 32'(cnt4), 0);
        chk("arst_rv4", 32'(rv4), 0);
        chk("arst_cnt8", 32'(cnt8), 0);
        chk("arst_full8", 32'(full8), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Parametrised successor to the team's basic synchronous FIFO, used for buffering between TPU stages such as the weight/activation feeders and the systolic array.
- Any DEPTH >= 2, not limited to powers of two; all DEPTH entries are usable.
- Valid/ready handshakes on both sides, occupancy count, programmable almost-full/almost-empty flags and synchronous flush.
- Selectable read mode: registered standard read, or first-word-fall-through (FWFT).

Parameters:
DEPTH, 8, number of entries; any integer >= 2
WIDTH, 16, data width in bits
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents, active high
wr_valid  input  1  write request
wr_ready  output  1  FIFO can accept a write
wr_data  input  WIDTH  write data
rd_ready  input  1  consumer request/accept
rd_valid  output  1  rd_data is valid
rd_data  output  WIDTH  read data
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH

Behaviour:
- Reset values (asynchronous on rstn low): pointers 0, count 0, rd_valid 0, rd_data 0, empty 1, full 0, almost_empty 1, almost_full 0 (unless AFULL_TH == 0). Storage array is not reset.
- Status flags and wr_ready are decoded from registered count only. There is no combinational path from rd_ready to wr_ready.
- wr_ready = !full.
- Push occurs when wr_valid && wr_ready. The word is written at wr_ptr, and wr_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0, including for non-power-of-two DEPTH.
- FWFT=0 (standard read):
  - Pop occurs when rd_ready && !empty.
  - rd_data is registered from mem[rd_ptr], and rd_valid = 1 on the next cycle (1-cycle latency).
  - rd_valid is 0 in any cycle following a non-pop.
  - rd_data holds its last value when there is no pop.
- FWFT=1 (first-word-fall-through):
  - rd_valid = !empty and rd_data = mem[rd_ptr], both combinational from registered state.
  - Pop occurs when rd_valid && rd_ready.
  - A written word is visible on rd_data in the cycle after the write (1-cycle write-to-read latency).
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance.
  - No push is possible while full. A pop while full frees a slot in the next cycle.
- Empty with simultaneous write: no pop that cycle. The data becomes readable in the following cycle (both modes).
- flush:
  - Has priority over push and pop in the same cycle; both are discarded.
  - Next cycle: pointers 0, count 0, rd_valid 0.
  - rd_data is unchanged in FWFT=0.
- Reset asserted mid-transfer aborts immediately. The in-flight word is lost, and outputs take their reset values asynchronously.
- Elaboration check: fatal error if DEPTH < 2, AFULL_TH > DEPTH, or AEMPTY_TH > DEPTH.

Optional Feature:
Macro: SYNC_FIFO_ERR_EN.
With the macro defined:
- Adds ports: err_clr input 1, overflow output 1, underflow output 1.
- overflow is a sticky flag, set the cycle after wr_valid && full.
- underflow is a sticky flag, set the cycle after rd_ready && empty.
- Both flags are cleared by err_clr, by flush, or by reset. If a new error occurs in the same cycle as err_clr, the set wins.
- A rejected write or read never changes FIFO state.
Without the macro: these ports and their logic are absent, and rejected requests are silently ignored.

Test Plan:
- DEPTH=5, FWFT=0: write 0x0001..0x0005 → full=1, wr_ready=0, count=5. A 6th write (0x0006) is dropped. Read 5 words → 0x0001..0x0005 in order, each 1 cycle after rd_ready. Then empty=1.
- DEPTH=5, wrap: 13 alternating write/read cycles → data order preserved across pointer wrap (0→4→0), and count never exceeds 1.
- Full with simultaneous read and write (wr_valid=1, rd_ready=1, FWFT=1, count=4 of DEPTH=4) → pop only that cycle; count=3 next cycle. Then simultaneous push+pop holds count=3.
- AFULL_TH=6, AEMPTY_TH=1, DEPTH=8: fill one word at a time → almost_empty deasserts at count=2, almost_full asserts at count=6, full asserts at count=8.
- flush asserted at count=3 together with wr_valid and rd_ready → next cycle count=0, empty=1, rd_valid=0. No word is emitted and the write is not stored.
- SYNC_FIFO_ERR_EN: read while empty → underflow=1 stays set. Write while full → overflow=1. Pulse err_clr → both flags 0 next cycle. FIFO count is unaffected throughout.
